seq_add64: RTL and testbench

- Multi-cycle 64-bit adder for the execute stage. It is the addition counterpart of the ripple subtractor.
- Computes a + b + cin one SLICE_W-bit slice per clock, holding a registered carry between slices.
- Reports sum, signed overflow and carry-out with a start/busy/done handshake.
- Used for slow-path address and accumulate operations where a full 64-bit ripple chain breaks timing.

---
 rtl/seq_add64.sv | 155 +++++++++++++++
 tb/tb_seq_add64.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_add64.sv
// Multi-cycle 64-bit adder: computes a + b + cin one SLICE_W-bit slice per clock.
// Optional zero/negative result flags are enabled by defining SEQ_ADD_NZ_FLAGS_EN.
module seq_add64 #(
  parameter int unsigned SLICE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic        busy,
  output logic        done,
  output logic [63:0] sum,
  output logic        overflow,
`ifdef SEQ_ADD_NZ_FLAGS_EN
  output logic        zero,
  output logic        negative,
`endif
  output logic        cout
);

  localparam int unsigned NSLICE = 64 / SLICE_W;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic [63:0]         op_a_q, op_a_d;
  logic [63:0]         op_b_q, op_b_d;
  logic [63:0]         sum_q, sum_d;
  logic                ovf_q, ovf_d;
  logic                cout_q, cout_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef SEQ_ADD_NZ_FLAGS_EN
  logic                zero_q, zero_d;
  logic                neg_q, neg_d;
`endif

  logic [5:0]          base;
  logic [SLICE_W-1:0]  slice_a, slice_b;
  logic [SLICE_W:0]    slice_res;
  logic                last_slice;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    sum_d    = sum_q;
    ovf_d    = ovf_q;
    cout_d   = cout_q;
`ifdef SEQ_ADD_NZ_FLAGS_EN
    zero_d   = zero_q;
    neg_d    = neg_q;
`endif
    // Multiplier of 64 truncates to 0, which is correct since cnt is always 0 then.
    base       = 6'(cnt_q) * 6'(SLICE_W);
    slice_a    = op_a_q[base +: SLICE_W];
    slice_b    = op_b_q[base +: SLICE_W];
    slice_res  = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE_W{1'b0}}, carry_q};
    last_slice = (cnt_q == CW'(NSLICE - 1));

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          op_a_d  = a;
          op_b_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          ovf_d   = 1'b0;
          cout_d  = 1'b0;
`ifdef SEQ_ADD_NZ_FLAGS_EN
          zero_d  = 1'b0;
          neg_d   = 1'b0;
`endif
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        sum_d[base +: SLICE_W] = slice_res[SLICE_W-1:0];
        carry_d = slice_res[SLICE_W];
        if (last_slice) begin
          state_d = StDone;
          cout_d  = slice_res[SLICE_W];
          // a63 ^ b63 ^ s63 recovers the carry into bit 63.
          ovf_d   = slice_a[SLICE_W-1] ^ slice_b[SLICE_W-1] ^ slice_res[SLICE_W-1]
                  ^ slice_res[SLICE_W];
`ifdef SEQ_ADD_NZ_FLAGS_EN
          zero_d  = (sum_d == 64'd0);
          neg_d   = sum_d[63];
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_ADD_NZ_FLAGS_EN
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEQ_ADD_NZ_FLAGS_EN
      zero_q  <= zero_d;
      neg_q   <= neg_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign overflow = ovf_q;
  assign cout     = cout_q;
`ifdef SEQ_ADD_NZ_FLAGS_EN
  assign zero     = zero_q;
  assign negative = neg_q;
`endif

endmodule

// File: tb/tb_seq_add64.sv
// Self-checking bench for seq_add64 using an expected-result queue.
// Zero/negative flags are checked when SEQ_ADD_NZ_FLAGS_EN is defined.
module tb_seq_add64;

  localparam int unsigned SLICE_W = 16;
  localparam int NSLICE = 64 / SLICE_W;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] a, b;
  logic        cin;
  logic        busy, done, overflow, cout;
  logic [63:0] sum;
`ifdef SEQ_ADD_NZ_FLAGS_EN
  logic        zero, negative;
`endif

  seq_add64 #(.SLICE_W(SLICE_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .overflow (overflow),
`ifdef SEQ_ADD_NZ_FLAGS_EN
    .zero     (zero),
    .negative (negative),
`endif
    .cout     (cout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] sum;
    logic        ovf;
    logic        cout;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic exp_t model(input logic [63:0] ia, input logic [63:0] ib, input logic ic);
    logic [64:0] r;
    exp_t e;
    r      = {1'b0, ia} + {1'b0, ib} + {64'd0, ic};
    e.sum  = r[63:0];
    e.cout = r[64];
    e.ovf  = (ia[63] == ib[63]) && (r[63] != ia[63]);
    return e;
  endfunction

  // Drives one start pulse and waits (bounded) for done; leaves us at the done negedge.
  task automatic run_op(input logic [63:0] ia, input logic [63:0] ib, input logic ic,
                        output int done_at, output int busy_cnt,
                        output logic [63:0] sum_at1, output logic cout_at1);
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    sb.push_back(model(ia, ib, ic));
    done_at = -1; busy_cnt = 0; sum_at1 = 'x; cout_at1 = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 1) begin sum_at1 = sum; cout_at1 = cout; end
      if (busy) busy_cnt++;
      if (done) begin done_at = i; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (sum !== 64'd0) begin n_fail++; $display("FAIL reset_sum: got %h want 0", sum); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", cout); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int d, bc; logic [63:0] s1; logic c1; exp_t e;
    run_op(64'd5, 64'd3, 1'b0, d, bc, s1, c1);
    e = sb.pop_front();
    n_checks++; if (d != NSLICE + 1) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", d, NSLICE + 1); end
    n_checks++; if (bc != NSLICE) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, NSLICE); end
    n_checks++; if (sum !== e.sum) begin n_fail++; $display("FAIL basic_sum: got %h want %h", sum, e.sum); end
    n_checks++; if ({overflow, cout} !== {e.ovf, e.cout}) begin
      n_fail++; $display("FAIL basic_flags: got %b%b want %b%b", overflow, cout, e.ovf, e.cout); end
    repeat (3) @(negedge clk);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle: got done=%b busy=%b want 0 0", done, busy); end
    n_checks++; if (sum !== e.sum) begin n_fail++; $display("FAIL basic_hold: got %h want %h", sum, e.sum); end
  endtask

  task automatic test_wrap;
    int d, bc; logic [63:0] s1; logic c1; exp_t e;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, d, bc, s1, c1);
    e = sb.pop_front();
    n_checks++; if (d != NSLICE + 1) begin n_fail++; $display("FAIL wrap_latency: got %0d want %0d", d, NSLICE + 1); end
    n_checks++; if (sum !== e.sum) begin n_fail++; $display("FAIL wrap_sum: got %h want %h", sum, e.sum); end
    n_checks++; if ({overflow, cout} !== {e.ovf, e.cout}) begin
      n_fail++; $display("FAIL wrap_flags: got %b%b want %b%b", overflow, cout, e.ovf, e.cout); end
    n_checks++; if (s1 !== 64'd0) begin n_fail++; $display("FAIL wrap_sum_cleared: got %h want 0", s1); end
`ifdef SEQ_ADD_NZ_FLAGS_EN
    n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL wrap_zero: got %b want 1", zero); end
`endif
  endtask

  task automatic test_overflow;
    int d, bc; logic [63:0] s1; logic c1; exp_t e;
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, d, bc, s1, c1);
    e = sb.pop_front();
    n_checks++; if (c1 !== 1'b0) begin n_fail++; $display("FAIL ovf_cout_cleared: got %b want 0", c1); end
    n_checks++; if (sum !== e.sum) begin n_fail++; $display("FAIL ovf_sum: got %h want %h", sum, e.sum); end
    n_checks++; if ({overflow, cout} !== {e.ovf, e.cout}) begin
      n_fail++; $display("FAIL ovf_flags: got %b%b want %b%b", overflow, cout, e.ovf, e.cout); end
`ifdef SEQ_ADD_NZ_FLAGS_EN
    n_checks++; if ({negative, zero} !== 2'b10) begin
      n_fail++; $display("FAIL ovf_nz: got %b%b want 10", negative, zero); end
`endif
  endtask

  task automatic test_back_to_back;
    int d1, d2, extra; exp_t e;
    @(negedge clk);
    a = 64'd10; b = 64'd20; cin = 1'b0; start = 1'b1;
    sb.push_back(model(64'd10, 64'd20, 1'b0));
    @(negedge clk);
    // start stays high through RUN with new operands; they must only take effect in DONE.
    a = 64'h8000_0000_0000_0000; b = 64'h8000_0000_0000_0000;
    sb.push_back(model(a, b, 1'b0));
    d1 = -1;
    for (int i = 1; i <= 20; i++) begin
      if (done) begin d1 = i; break; end
      @(negedge clk);
    end
    e = sb.pop_front();
    n_checks++; if (d1 != NSLICE + 1) begin n_fail++; $display("FAIL b2b_op1_latency: got %0d want %0d", d1, NSLICE + 1); end
    n_checks++; if (sum !== e.sum || {overflow, cout} !== {e.ovf, e.cout}) begin
      n_fail++; $display("FAIL b2b_op1: got %h %b%b want %h %b%b", sum, overflow, cout, e.sum, e.ovf, e.cout); end
    d2 = -1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin d2 = j; break; end
    end
    e = sb.pop_front();
    n_checks++; if (d2 != NSLICE + 1) begin n_fail++; $display("FAIL b2b_op2_latency: got %0d want %0d", d2, NSLICE + 1); end
    n_checks++; if (sum !== e.sum || {overflow, cout} !== {e.ovf, e.cout}) begin
      n_fail++; $display("FAIL b2b_op2: got %h %b%b want %h %b%b", sum, overflow, cout, e.sum, e.ovf, e.cout); end
    extra = 0;
    repeat (6) begin @(negedge clk); if (done) extra++; end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL b2b_extra_done: got %0d want 0", extra); end
  endtask

  task automatic test_reset_abort;
    int d, bc, dn; logic [63:0] s1; logic c1; exp_t e;
    @(negedge clk);
    a = 64'h0001_0001_0001_0001; b = 64'h0001_0001_0001_0001; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || sum === 64'd0) begin
      n_fail++; $display("FAIL abort_pre: got busy=%b sum=%h want busy=1 sum nonzero", busy, sum); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if ({busy, done, overflow, cout} !== 4'b0000 || sum !== 64'd0) begin
      n_fail++; $display("FAIL abort_async: got busy=%b done=%b ovf=%b cout=%b sum=%h want all 0",
                         busy, done, overflow, cout, sum); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (8) begin @(negedge clk); if (done) dn++; end
    n_checks++; if (dn != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", dn); end
    run_op(64'd1, 64'd1, 1'b1, d, bc, s1, c1);
    e = sb.pop_front();
    n_checks++; if (d < 0 || sum !== e.sum || sum !== 64'd3) begin
      n_fail++; $display("FAIL abort_restart: got %h (done_at %0d) want %h", sum, d, e.sum); end
  endtask

  task automatic test_operand_change;
    int d; exp_t e;
    @(negedge clk);
    a = 64'h1234_0000_0000_0000; b = 64'h0000_0000_0000_4321; cin = 1'b0; start = 1'b1;
    sb.push_back(model(a, b, cin));
    d = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin d = i; break; end
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom);
    end
    e = sb.pop_front();
    n_checks++; if (d < 0 || sum !== e.sum) begin
      n_fail++; $display("FAIL opchange_sum: got %h (done_at %0d) want %h", sum, d, e.sum); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    test_operand_change();
    n_checks++; if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
